// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display path.
// The segment decoder uses the same anode patterns.
package sseg_pkg;

  // Active-low anode patterns, one per digit, plus all-off.
  localparam logic [3:0] AN_DIGIT0 = 4'hE;
  localparam logic [3:0] AN_DIGIT1 = 4'hD;
  localparam logic [3:0] AN_DIGIT2 = 4'hB;
  localparam logic [3:0] AN_DIGIT3 = 4'h7;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  // Digit index; wraps naturally from 3 back to 0.
  typedef logic [1:0] digit_idx_t;

  // Outcome of the frame-end arbitration.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_KB   = 2'd1,
    GRANT_CPU  = 2'd2
  } grant_e;

  // Map a digit index to its anode pattern.
  function automatic logic [3:0] an_of_idx(input digit_idx_t idx);
    logic [3:0] an;
    unique case (idx)
      2'd0:    an = AN_DIGIT0;
      2'd1:    an = AN_DIGIT1;
      2'd2:    an = AN_DIGIT2;
      default: an = AN_DIGIT3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// Refresh prescaler and digit-index counter. The prescaler counts
// 0..REFRESH_DIV-1; on its terminal count the digit index advances.
// frame_end_o marks the terminal count of the last digit.
module sseg_refresh_timer
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_i,
  output digit_idx_t idx_o,
  output logic       step_o,
  output logic       frame_end_o
);

  localparam int              CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TC   = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  digit_idx_t       idx_q, idx_d;
  logic             terminal;

  // Next-state logic for prescaler and digit index.
  always_comb begin
    terminal = (presc_q == TC);
    presc_d  = terminal ? '0 : presc_q + CNT_W'(1);
    idx_d    = terminal ? idx_q + 2'd1 : idx_q;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the
    // pre-edge value of every other flop, regardless of statement order.
    if (reset_i) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o       = idx_q;
  assign step_o      = terminal;
  assign frame_end_o = terminal && (idx_q == 2'd3);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan and update controller for the 4-digit seven-segment display.
// Drives the anode rotation and owns the committed display value.
// Keyboard and CPU updates are arbitrated round-robin and committed
// only at frame end, so a displayed value never tears mid-frame.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kb_req,
  input  logic [15:0] kb_data,
  output logic        kb_ack,
  input  logic        cpu_req,
  input  logic [15:0] cpu_data,
  output logic        cpu_ack,
  input  logic        blank,
  output logic [15:0] disp_data,
  output logic [3:0]  AN,
  output logic        frame_tick
);

  digit_idx_t  idx, idx_next;
  logic        step;
  logic        frame_end;
  grant_e      grant;

  logic [15:0] disp_q, disp_d;
  logic [3:0]  an_q, an_d;
  logic        prio_cpu_q, prio_cpu_d;  // 1: CPU wins the next tie
  logic        kb_ack_q, cpu_ack_q, tick_q;

  sseg_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk         (clk),
    .reset_i     (reset),
    .idx_o       (idx),
    .step_o      (step),
    .frame_end_o (frame_end)
  );

  // Frame-end arbitration: the requester not granted most recently wins a tie.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = GRANT_NONE;
    if (frame_end) begin
      if (kb_req && cpu_req) grant = prio_cpu_q ? GRANT_CPU : GRANT_KB;
      else if (cpu_req)      grant = GRANT_CPU;
      else if (kb_req)       grant = GRANT_KB;
    end
  end

  // Next display value, round-robin pointer and anode pattern.
  always_comb begin
    disp_d     = disp_q;
    prio_cpu_d = prio_cpu_q;
    unique case (grant)
      GRANT_KB: begin
        disp_d     = kb_data;
        prio_cpu_d = 1'b1;
      end
      GRANT_CPU: begin
        disp_d     = cpu_data;
        prio_cpu_d = 1'b0;
      end
      default: ;
    endcase
    idx_next = step ? idx + 2'd1 : idx;
    an_d     = blank ? AN_BLANK : an_of_idx(idx_next);
  end

  // Output and state registers; reset discards any pending grant.
  always_ff @(posedge clk) begin
    // NOTE: only control and output state is reset here; the display value
    // is a small register (not a memory), so clearing it is cheap and required.
    if (reset) begin
      disp_q     <= 16'h0000;
      an_q       <= AN_DIGIT0;
      prio_cpu_q <= 1'b1;
      kb_ack_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      an_q       <= an_d;
      prio_cpu_q <= prio_cpu_d;
      kb_ack_q   <= (grant == GRANT_KB);
      cpu_ack_q  <= (grant == GRANT_CPU);
      tick_q     <= frame_end;
    end
  end

  assign disp_data  = disp_q;
  assign AN         = an_q;
  assign kb_ack     = kb_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign frame_tick = tick_q;

endmodule
